pdes_ctrl: RTL

PDES_CTRL -- requirements
Module: pdes_ctrl

---
 rtl/pdes_pkg.sv | 32 +++
 rtl/pdes_gvt_min.sv | 19 +
 rtl/pdes_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pdes_pkg.sv
// Shared types and constants for the PDES run controller: FSM states, AEG map,
// run status codes, CSR addresses and exception bit positions.
package pdes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_FINISHED = 2'd2
   } state_t;

   localparam logic [17:0] AEG_BASE    = 18'd0;
   localparam logic [17:0] AEG_END     = 18'd1;
   localparam logic [17:0] AEG_LIMIT   = 18'd2;
   localparam logic [17:0] AEG_RESULT  = 18'd3;
   localparam logic [17:0] AEG_ELAPSED = 18'd4;
   localparam logic [17:0] AEG_STATUS  = 18'd5;
   localparam logic [17:0] AEG_CNT     = 18'd6;

   localparam logic [1:0] STAT_NONE    = 2'd0;
   localparam logic [1:0] STAT_DONE    = 2'd1;
   localparam logic [1:0] STAT_TIMEOUT = 2'd2;

   localparam logic [15:0] CSR_STATE   = 16'h0;
   localparam logic [15:0] CSR_RESULT  = 16'h1;
   localparam logic [15:0] CSR_ELAPSED = 16'h2;
   localparam logic [15:0] CSR_DONE    = 16'h3;

   localparam int EXC_INST = 0;
   localparam int EXC_IDX  = 1;
   localparam int EXC_RO   = 2;

endpackage

// File: rtl/pdes_gvt_min.sv
// Unsigned minimum over NUM_ENG packed virtual times (engine 0 in the LSBs).
module pdes_gvt_min #(
   parameter int NUM_ENG = 4,
   parameter int GVT_W   = 14
) (
   input  logic [NUM_ENG*GVT_W-1:0] i_gvt,
   output logic [GVT_W-1:0]         o_min
);

   always_comb begin
      o_min = i_gvt[GVT_W-1:0];
      for (int i = 1; i < NUM_ENG; i++) begin
         if (i_gvt[i*GVT_W +: GVT_W] < o_min) begin
            o_min = i_gvt[i*GVT_W +: GVT_W];
         end
      end
   end

endmodule

// File: rtl/pdes_ctrl.sv
// PDES run controller: AEG register file, run FSM with completion/timeout
// detection, per-engine GVT capture and CSR readback.
module pdes_ctrl
   import pdes_pkg::*;
#(
   parameter int NUM_ENG = 4,
   parameter int GVT_W   = 14,
   parameter int CYC_W   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     disp_inst_vld,
   input  logic [4:0]               disp_inst,
   input  logic [17:0]              disp_aeg_idx,
   input  logic                     disp_aeg_rd,
   input  logic                     disp_aeg_wr,
   input  logic [63:0]              disp_aeg_wr_data,
   output logic [17:0]              disp_aeg_cnt,
   output logic [15:0]              disp_exception,
   output logic                     disp_idle,
   output logic                     disp_stall,
   output logic                     disp_rtn_data_vld,
   output logic [63:0]              disp_rtn_data,
   output logic [NUM_ENG-1:0]       eng_en,
   output logic [47:0]              eng_addr,
   output logic [GVT_W-1:0]         eng_end_time,
   input  logic [NUM_ENG-1:0]       eng_done,
   input  logic [NUM_ENG*GVT_W-1:0] eng_gvt,
   input  logic                     csr_rd_vld,
   input  logic [15:0]              csr_address,
   output logic                     csr_rd_ack,
   output logic [63:0]              csr_rd_data
);

   state_t                   r_state, w_state_next;
   logic                     r_start;
   logic [63:0]              r_aeg_base, r_aeg_end, r_aeg_limit, r_aeg_result;
   logic [1:0]               r_status;
   logic [CYC_W-1:0]         r_cnt, w_cnt_inc;
   logic [NUM_ENG-1:0]       r_done, w_done_next;
   logic [NUM_ENG*GVT_W-1:0] r_gvt;
   logic [GVT_W-1:0]         w_gvt_min;
   logic                     w_start_dec, w_enter_run, w_all_done, w_lim_hit;
   logic [63:0]              w_aeg_rd_data, w_csr_data;
   logic [15:0]              w_exc, r_exc;
   logic                     r_rtn_vld, r_csr_ack;
   logic [63:0]              r_rtn_data, r_csr_data;

   pdes_gvt_min #(.NUM_ENG(NUM_ENG), .GVT_W(GVT_W)) u_gvt_min (
      .i_gvt (r_gvt),
      .o_min (w_gvt_min)
   );

   assign w_start_dec = disp_inst_vld && (disp_inst == 5'd0);
   assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CYC_W'(1);
   // Completion and limit look at this cycle's incoming pulses/increment so that
   // a pulse coinciding with the limit cycle is recognised as a normal finish.
   assign w_done_next = r_done | eng_done;
   assign w_all_done  = &w_done_next;
   assign w_lim_hit   = (r_aeg_limit != 64'd0) && (64'(w_cnt_inc) == r_aeg_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_enter_run  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_start) begin
               w_state_next = ST_RUNNING;
               w_enter_run  = 1'b1;
            end
         end
         ST_RUNNING:  if (w_all_done || w_lim_hit) w_state_next = ST_FINISHED;
         ST_FINISHED: w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_exc           = '0;
      w_exc[EXC_INST] = disp_inst_vld && (disp_inst != 5'd0);
      w_exc[EXC_IDX]  = (disp_aeg_rd || disp_aeg_wr) && (disp_aeg_idx >= AEG_CNT);
      w_exc[EXC_RO]   = disp_aeg_wr && (disp_aeg_idx >= AEG_RESULT) && (disp_aeg_idx < AEG_CNT);
   end

   always_comb begin
      w_aeg_rd_data = '0;
      case (disp_aeg_idx)
         AEG_BASE:    w_aeg_rd_data = r_aeg_base;
         AEG_END:     w_aeg_rd_data = r_aeg_end;
         AEG_LIMIT:   w_aeg_rd_data = r_aeg_limit;
         AEG_RESULT:  w_aeg_rd_data = r_aeg_result;
         AEG_ELAPSED: w_aeg_rd_data = 64'(r_cnt);
         AEG_STATUS:  w_aeg_rd_data = 64'(r_status);
         default:     ;
      endcase
   end

   always_comb begin
      w_csr_data = '0;
      case (csr_address)
         CSR_STATE:   w_csr_data = 64'(r_state);
         CSR_RESULT:  w_csr_data = r_aeg_result;
         CSR_ELAPSED: w_csr_data = 64'(r_cnt);
         CSR_DONE:    w_csr_data = 64'(r_done);
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start      <= 1'b0;
         r_aeg_base   <= '0;
         r_aeg_end    <= '0;
         r_aeg_limit  <= '0;
         r_aeg_result <= '0;
         r_status     <= STAT_NONE;
         r_cnt        <= '0;
         r_done       <= '0;
         r_gvt        <= '0;
      end else begin
         if (w_enter_run)
            r_start <= 1'b0;
         else if (w_start_dec && (r_state == ST_IDLE))
            r_start <= 1'b1;

         if (disp_aeg_wr && (r_state == ST_IDLE)) begin
            case (disp_aeg_idx)
               AEG_BASE:  r_aeg_base  <= disp_aeg_wr_data;
               AEG_END:   r_aeg_end   <= disp_aeg_wr_data;
               AEG_LIMIT: r_aeg_limit <= disp_aeg_wr_data;
               default:   ;
            endcase
         end

         if (w_enter_run) begin
            r_done       <= '0;
            r_cnt        <= '0;
            r_aeg_result <= '0;
            r_status     <= STAT_NONE;
         end else if (r_state == ST_RUNNING) begin
            r_cnt  <= w_cnt_inc;
            r_done <= w_done_next;
            for (int i = 0; i < NUM_ENG; i++) begin
               if (!r_done[i]) r_gvt[i*GVT_W +: GVT_W] <= eng_gvt[i*GVT_W +: GVT_W];
            end
            if (w_all_done)     r_status <= STAT_DONE;
            else if (w_lim_hit) r_status <= STAT_TIMEOUT;
         end else if (r_state == ST_FINISHED) begin
            r_aeg_result <= 64'(w_gvt_min);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exc      <= '0;
         r_rtn_vld  <= 1'b0;
         r_rtn_data <= '0;
         r_csr_ack  <= 1'b0;
         r_csr_data <= '0;
      end else begin
         r_exc      <= w_exc;
         r_rtn_vld  <= disp_aeg_rd;
         r_rtn_data <= disp_aeg_rd ? w_aeg_rd_data : 64'd0;
         r_csr_ack  <= csr_rd_vld;
         r_csr_data <= csr_rd_vld ? w_csr_data : 64'd0;
      end
   end

   assign disp_aeg_cnt      = AEG_CNT;
   assign disp_exception    = r_exc;
   assign disp_idle         = (r_state == ST_IDLE) && !r_start;
   assign disp_stall        = (r_state != ST_IDLE) || w_start_dec || r_start;
   assign disp_rtn_data_vld = r_rtn_vld;
   assign disp_rtn_data     = r_rtn_data;
   assign eng_en            = {NUM_ENG{r_state == ST_RUNNING}};
   assign eng_addr          = r_aeg_base[47:0];
   assign eng_end_time      = r_aeg_end[GVT_W-1:0];
   assign csr_rd_ack        = r_csr_ack;
   assign csr_rd_data       = r_csr_data;

endmodule
